// File: rtl/payload_buffer.sv
// Circular side-payload buffer (imm/pc) with in-order free and tail rollback on squash.
// Define PAYLOAD_BUFFER_BYPASS_EN to forward same-cycle enqueue data to matching read ports.
module payload_buffer #(
    parameter int DEPTH   = 32,
    parameter int WIDTH   = 20,
    parameter int ENQ_NUM = 4,
    parameter int RD_NUM  = 2,
    parameter int CMT_NUM = 4,
    localparam int PTRW   = $clog2(DEPTH),
    localparam int IDXW   = PTRW + 1,
    localparam int CMTW   = $clog2(CMT_NUM + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ENQ_NUM-1:0]        i_enq_req,
    input  logic [ENQ_NUM*WIDTH-1:0]  i_enq_data,
    output logic                      o_can_enq,
    output logic [ENQ_NUM*IDXW-1:0]   o_alloc_idx,
    input  logic [RD_NUM*IDXW-1:0]    i_rd_idx,
    output logic [RD_NUM*WIDTH-1:0]   o_rd_data,
    input  logic [CMTW-1:0]           i_cmt_num,
    input  logic                      i_squash_vld,
    input  logic [IDXW-1:0]           i_squash_idx,
    output logic [IDXW-1:0]           o_count,
    output logic                      o_empty,
    output logic                      o_full
);

    logic [IDXW-1:0]          head_q, head_d;
    logic [IDXW-1:0]          tail_q, tail_d;
    logic [RD_NUM*WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [WIDTH-1:0]         mem_q [DEPTH];

    logic [IDXW-1:0]          count;
    logic [IDXW:0]            free_cnt;
    logic                     enq_fire;
    logic [IDXW-1:0]          enq_total;
    logic [IDXW-1:0]          slot_idx [ENQ_NUM];
    logic                     rd_flags_unused;

    always_comb begin
        count       = tail_q - head_q;
        free_cnt    = (IDXW+1)'(DEPTH) - {1'b0, count};
        o_can_enq   = free_cnt >= (IDXW+1)'(ENQ_NUM);
        enq_fire    = (|i_enq_req) && o_can_enq && !i_squash_vld;
        enq_total   = '0;
        o_alloc_idx = '0;
        // Requesting ports get consecutive slots in port order.
        for (int i = 0; i < ENQ_NUM; i++) begin
            slot_idx[i] = tail_q + enq_total;
            o_alloc_idx[i*IDXW +: IDXW] = slot_idx[i];
            enq_total = enq_total + IDXW'(i_enq_req[i]);
        end
        head_d = head_q + IDXW'(i_cmt_num);
        tail_d = tail_q;
        if (i_squash_vld) begin
            tail_d = i_squash_idx;
        end else if (enq_fire) begin
            tail_d = tail_q + enq_total;
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int r = 0; r < RD_NUM; r++) begin
            rd_data_d[r*WIDTH +: WIDTH] = mem_q[i_rd_idx[r*IDXW +: PTRW]];
`ifdef PAYLOAD_BUFFER_BYPASS_EN
            for (int e = 0; e < ENQ_NUM; e++) begin
                if (enq_fire && i_enq_req[e] &&
                    slot_idx[e][PTRW-1:0] == i_rd_idx[r*IDXW +: PTRW]) begin
                    rd_data_d[r*WIDTH +: WIDTH] = i_enq_data[e*WIDTH +: WIDTH];
                end
            end
`endif
        end
    end

    always_comb begin
        rd_flags_unused = 1'b0;
        for (int r = 0; r < RD_NUM; r++) begin
            rd_flags_unused = rd_flags_unused ^ i_rd_idx[r*IDXW + PTRW];
        end
    end

    // Storage is never reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENQ_NUM; e++) begin
            if (enq_fire && i_enq_req[e]) begin
                mem_q[slot_idx[e][PTRW-1:0]] <= i_enq_data[e*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            rd_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_count   = count;
    assign o_empty   = (count == '0);
    assign o_full    = (count == IDXW'(DEPTH));

`ifndef SYNTHESIS
    a_enq_no_room: assert property (@(posedge clk) disable iff (!rst)
        !((|i_enq_req) && !o_can_enq));
    a_cmt_over: assert property (@(posedge clk) disable iff (!rst)
        IDXW'(i_cmt_num) <= count);
    // Squash target must lie between the post-commit head and the tail.
    a_squash_rng: assert property (@(posedge clk) disable iff (!rst)
        i_squash_vld |-> ((i_squash_idx - head_d) <= (tail_q - head_d)));
`endif

endmodule

// File: tb/tb_payload_buffer.sv
// Scoreboard bench for payload_buffer: default 32-entry build plus a tiny
// 8-entry single-port instance to reach the full condition.
module tb_payload_buffer;

    localparam int D  = 32;
    localparam int W  = 20;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [4*W-1:0] data;
    logic          can_enq;
    logic [4*IW-1:0] alloc;
    logic [2*IW-1:0] rd_idx;
    logic [2*W-1:0]  rd_data;
    logic [2:0]    cmt;
    logic          sq;
    logic [IW-1:0] sqidx;
    logic [IW-1:0] count;
    logic          empty, full;

    logic [0:0]    s_req;
    logic [7:0]    s_data;
    logic          s_can;
    logic [3:0]    s_alloc;
    logic [3:0]    s_rd_idx;
    logic [7:0]    s_rd_data;
    logic [0:0]    s_cmt;
    logic          s_sq;
    logic [3:0]    s_sqidx;
    logic [3:0]    s_count;
    logic          s_empty, s_full;

    always #5 clk = ~clk;

    payload_buffer u_dut (
        .clk(clk), .rst(rst),
        .i_enq_req(req), .i_enq_data(data),
        .o_can_enq(can_enq), .o_alloc_idx(alloc),
        .i_rd_idx(rd_idx), .o_rd_data(rd_data),
        .i_cmt_num(cmt), .i_squash_vld(sq), .i_squash_idx(sqidx),
        .o_count(count), .o_empty(empty), .o_full(full)
    );

    payload_buffer #(
        .DEPTH(8), .WIDTH(8), .ENQ_NUM(1), .RD_NUM(1), .CMT_NUM(1)
    ) u_small (
        .clk(clk), .rst(rst),
        .i_enq_req(s_req), .i_enq_data(s_data),
        .o_can_enq(s_can), .o_alloc_idx(s_alloc),
        .i_rd_idx(s_rd_idx), .o_rd_data(s_rd_data),
        .i_cmt_num(s_cmt), .i_squash_vld(s_sq), .i_squash_idx(s_sqidx),
        .o_count(s_count), .o_empty(s_empty), .o_full(s_full)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  mdl [D];
    bit            known [D];
    logic [IW-1:0] m_head = '0;
    logic [IW-1:0] m_tail = '0;
    logic [W:0]    sb [$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [IW-1:0] cnt, t;
        logic [4:0]    p;
        logic [W:0]    e;
        bit            can, fire;
        cnt  = m_tail - m_head;
        can  = (D - int'(cnt)) >= 4;
        fire = (req != 0) && can && !sq;
        for (int r = 0; r < 2; r++) begin
            p = rd_idx[r*IW +: 5];
            e = {known[p], mdl[p]};
`ifdef PAYLOAD_BUFFER_BYPASS_EN
            t = m_tail;
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (fire && t[4:0] == p) e = {1'b1, data[i*W +: W]};
                    t++;
                end
            end
`endif
            sb.push_back(e);
        end
        t = m_tail;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                if (fire) begin
                    mdl[t[4:0]]   = data[i*W +: W];
                    known[t[4:0]] = 1'b1;
                end
                t++;
            end
        end
        m_head = m_head + IW'(cmt);
        if (sq) m_tail = sqidx;
        else if (fire) m_tail = t;
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            e = sb.pop_front();
            if (e[W]) chk($sformatf("rd%0d", r), 64'(rd_data[r*W +: W]), 64'(e[W-1:0]));
        end
        cnt = m_tail - m_head;
        chk("count", 64'(count), 64'(cnt));
        chk("empty", 64'(empty), 64'(cnt == 0));
        chk("full", 64'(full), 64'(cnt == 32));
        chk("can_enq", 64'(can_enq), 64'((D - int'(cnt)) >= 4));
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) data[i*W +: W] = W'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = '0; data = '0; rd_idx = '0; cmt = '0; sq = 1'b0; sqidx = '0;
        s_req = '0; s_data = '0; s_rd_idx = '0; s_cmt = '0; s_sq = 1'b0; s_sqidx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_can", 64'(can_enq), 64'd1);
        chk("rst_rd", 64'(rd_data), 64'd0);
        rst = 1'b1;

        // sparse enqueue
        req = 4'b0101;
        data[0*W +: W] = 20'hA;
        data[2*W +: W] = 20'hB;
        #1;
        chk("t2_alloc0", 64'(alloc[0*IW +: IW]), 64'd0);
        chk("t2_alloc2", 64'(alloc[2*IW +: IW]), 64'd1);
        tick();
        req = '0;
        rd_idx = {6'd0, 6'd1};
        tick();

        // fill up to 29
        cmt = 3'd2; tick(); cmt = '0;
        repeat (7) begin
            req = 4'hF; rand_data();
            rd_idx = {6'($urandom_range(0, 31)), 6'($urandom_range(0, 31))};
            tick();
        end
        req = 4'b0001; rand_data(); tick();
        req = '0;
        chk("t3_can29", 64'(can_enq), 64'd0);
        cmt = 3'd4; tick(); cmt = '0;
        chk("t3_can25", 64'(can_enq), 64'd1);

        // wrap
        sq = 1'b1; sqidx = 6'd30; tick(); sq = 1'b0;
        repeat (6) begin cmt = 3'd4; tick(); end
        cmt = '0;
        req = 4'hF; rand_data(); #1;
        chk("t4_a0", 64'(alloc[0*IW +: IW]), 64'd30);
        chk("t4_a1", 64'(alloc[1*IW +: IW]), 64'd31);
        chk("t4_a2", 64'(alloc[2*IW +: IW]), 64'd32);
        chk("t4_a3", 64'(alloc[3*IW +: IW]), 64'd33);
        tick();
        req = 4'b0001; #1;
        chk("t4_tail", 64'(alloc[0*IW +: IW]), 64'd34);
        req = '0;
        rd_idx = {6'd33, 6'd32};
        tick();

        // squash with commit and enqueue in the same cycle
        cmt = 3'd2; tick(); cmt = '0;
        req = 4'hF; rand_data(); tick();
        rand_data(); tick();
        sq = 1'b1; sqidx = 6'd37; cmt = 3'd2; rand_data(); tick();
        sq = 1'b0; cmt = '0;
        req = 4'b0001; #1;
        chk("t5_tail", 64'(alloc[0*IW +: IW]), 64'd37);
        req = '0;
        sq = 1'b1; sqidx = 6'd37; tick(); sq = 1'b0;

        // same-cycle read of the slot being written
        req = 4'b0011; rand_data(); tick();
        req = 4'b0001; data[0*W +: W] = 20'h55; rd_idx = {6'd39, 6'd7};
        tick();
        req = '0; tick();

        // commit and enqueue together
        cmt = 3'd3; req = 4'b0110; rand_data(); tick();
        cmt = '0; req = '0;
        chk("ce_count", 64'(count), 64'd5);

        // asynchronous reset mid-operation
        @(posedge clk); #3;
        rst = 1'b0; #1;
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_empty", 64'(empty), 64'd1);
        chk("mr_rd", 64'(rd_data), 64'd0);
        m_head = '0; m_tail = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        req = 4'b1000; data[3*W +: W] = 20'h77; #1;
        chk("mr_alloc3", 64'(alloc[3*IW +: IW]), 64'd0);
        tick();
        req = '0; rd_idx = {6'd0, 6'd0}; tick();

        // small instance reaches full
        for (int i = 0; i < 8; i++) begin
            s_req = 1'b1; s_data = 8'h10 + 8'(i); #1;
            chk("s_alloc", 64'(s_alloc), 64'(i));
            @(posedge clk); #1;
        end
        s_req = '0;
        chk("s_full", 64'(s_full), 64'd1);
        chk("s_count8", 64'(s_count), 64'd8);
        chk("s_can0", 64'(s_can), 64'd0);
        s_rd_idx = 4'd3; s_cmt = 1'b1;
        @(posedge clk); #1;
        s_cmt = '0;
        chk("s_rd", 64'(s_rd_data), 64'h13);
        chk("s_count7", 64'(s_count), 64'd7);
        chk("s_nfull", 64'(s_full), 64'd0);
        chk("s_can1", 64'(s_can), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
